// File: rtl/pic8259_pkg.sv
// pic8259_pkg: shared command codes, read-select codes and init-sequence states
package pic8259_pkg;
  localparam logic [2:0] ICW1      = 3'd0;
  localparam logic [2:0] ICW2      = 3'd1;
  localparam logic [2:0] ICW3      = 3'd2;
  localparam logic [2:0] ICW4      = 3'd3;
  localparam logic [2:0] OCW1      = 3'd4;
  localparam logic [2:0] OCW2      = 3'd5;
  localparam logic [2:0] OCW3      = 3'd6;
  localparam logic [2:0] FLAG_IDLE = 3'b111;
  localparam logic [2:0] RS_IMR    = 3'b011;
  localparam logic [2:0] RS_IRR    = 3'b001;
  localparam logic [2:0] RS_ISR    = 3'b101;
  localparam logic [2:0] RS_NONE   = 3'b000;
  typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} pic_state_e;
endpackage

// File: rtl/pic_bus_edge_sync.sv
// pic_bus_edge_sync: optional strobe synchronizer plus write-completion and read-active detection
module pic_bus_edge_sync #(
  parameter bit SYNC_INPUTS = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic wr_act,
  output logic wr_done,
  output logic rd_act
);
  logic [2:0] s1_q, s1_d, s2_q, s2_d, bus;
  logic       wr_act_q, wr_act_d, blk_q, blk_d;
  // Synchronizer stages carry no reset so they keep tracking the bus while rst_n is low
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end
  // Write-active history; blk_q hides a write already in progress when reset was applied
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_act_q <= 1'b0;
      blk_q    <= 1'b1;
    end else begin
      wr_act_q <= wr_act_d;
      blk_q    <= blk_d;
    end
  end
  // Strobe decode and completion-edge detection
  always_comb begin
    s1_d     = {cs_n, rd_n, wr_n};
    s2_d     = s1_q;
    bus      = SYNC_INPUTS ? s2_q : {cs_n, rd_n, wr_n};
    wr_act   = !bus[2] && !bus[0];
    rd_act   = !bus[2] && !bus[1] && !wr_act;
    wr_act_d = wr_act && !blk_q;
    blk_d    = blk_q && wr_act;
    wr_done  = !wr_act && wr_act_q;
  end
endmodule

// File: rtl/pic_rw_sequencer.sv
// pic_rw_sequencer: 8259 bus front end tracking the ICW sequence and classifying writes and reads
module pic_rw_sequencer
  import pic8259_pkg::*;
#(
  parameter bit         SYNC_INPUTS = 1'b1,
  parameter logic [2:0] FLAG_IDLE   = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic [7:0] write_data,
  output logic [2:0] write_flag,
  output logic       write_strobe,
  output logic [2:0] read_select,
  output logic       read_enable,
  output logic       init_done,
  output logic       sngl,
  output logic       ic4
);
  pic_state_e state_q, state_d;
  logic [7:0] cap_data_q, cap_data_d, wdata_q, wdata_d;
  logic [2:0] flag_q, flag_d, rs_q, rs_d, code;
  logic       cap_a0_q, cap_a0_d, strobe_q, strobe_d, ren_q, ren_d, init_q, init_d;
  logic       sngl_q, sngl_d, ic4_q, ic4_d, rr_q, rr_d, ris_q, ris_d, hit;
  logic       wr_act, wr_done, rd_act;
  pic_bus_edge_sync #(.SYNC_INPUTS(SYNC_INPUTS)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs_n   (cs_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .wr_act (wr_act),
    .wr_done(wr_done),
    .rd_act (rd_act)
  );
  // State, captured bus values and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= UNINIT;
      cap_data_q <= 8'h00;
      cap_a0_q   <= 1'b0;
      wdata_q    <= 8'h00;
      flag_q     <= FLAG_IDLE;
      strobe_q   <= 1'b0;
      rs_q       <= RS_NONE;
      ren_q      <= 1'b0;
      init_q     <= 1'b0;
      sngl_q     <= 1'b0;
      ic4_q      <= 1'b0;
      rr_q       <= 1'b1;
      ris_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_data_q <= cap_data_d;
      cap_a0_q   <= cap_a0_d;
      wdata_q    <= wdata_d;
      flag_q     <= flag_d;
      strobe_q   <= strobe_d;
      rs_q       <= rs_d;
      ren_q      <= ren_d;
      init_q     <= init_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      rr_q       <= rr_d;
      ris_q      <= ris_d;
    end
  end
  // Capture while writing, decode on the completion cycle, select the read source
  always_comb begin
    cap_data_d = wr_act ? data_in : cap_data_q;
    cap_a0_d   = wr_act ? a0 : cap_a0_q;
    wdata_d    = wr_done ? cap_data_q : wdata_q;
    state_d    = state_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    rr_d       = rr_q;
    ris_d      = ris_q;
    code       = FLAG_IDLE;
    hit        = 1'b0;
    if (wr_done) begin
      if (!cap_a0_q && cap_data_q[4]) begin
        code    = ICW1;
        hit     = 1'b1;
        sngl_d  = cap_data_q[1];
        ic4_d   = cap_data_q[0];
        rr_d    = 1'b1;
        ris_d   = 1'b0;
        state_d = WAIT_ICW2;
      end else if (cap_a0_q) begin
        case (state_q)
          WAIT_ICW2: begin
            code    = ICW2;
            hit     = 1'b1;
            state_d = !sngl_q ? WAIT_ICW3 : ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW3: begin
            code    = ICW3;
            hit     = 1'b1;
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            code    = ICW4;
            hit     = 1'b1;
            state_d = READY;
          end
          READY: begin
            code = OCW1;
            hit  = 1'b1;
          end
          default: ;
        endcase
      end else if (state_q == READY) begin
        code  = cap_data_q[3] ? OCW3 : OCW2;
        hit   = 1'b1;
        rr_d  = (cap_data_q[3] && cap_data_q[1]) ? 1'b1 : rr_q;
        ris_d = (cap_data_q[3] && cap_data_q[1]) ? cap_data_q[0] : ris_q;
      end
    end
    flag_d   = hit ? code : FLAG_IDLE;
    strobe_d = hit;
    init_d   = state_d == READY;
    ren_d    = rd_act;
    rs_d     = !rd_act ? RS_NONE : a0 ? RS_IMR : (rr_q && ris_q) ? RS_ISR : RS_IRR;
  end
  assign write_data   = wdata_q;
  assign write_flag   = flag_q;
  assign write_strobe = strobe_q;
  assign read_select  = rs_q;
  assign read_enable  = ren_q;
  assign init_done    = init_q;
  assign sngl         = sngl_q;
  assign ic4          = ic4_q;
endmodule
